// File: rtl/ram_lvt_mrmw.sv
// ram_lvt_mrmw: multi-read / multi-write RAM built from replicated 1R1W banks
// and a Live Value Table (LVT).
//   Write port w owns bank row w and keeps one copy of it per read port. The
//   LVT remembers, per address, which write port wrote last. Each read port
//   uses that entry to pick the right row.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   w_enb        per-write-port enable        (NUM_W)
//   w_addr/w_din packed write address/data    (port w at [w*W +: W])
//   r_enb        per-read-port enable         (NUM_R)
//   r_addr       packed read addresses
//   r_dout       packed registered read data (holds while r_enb is low)
//   r_valid      per-port read-data valid, one cycle after r_enb
//   w_conflict   pulse: two or more enabled writes hit one address last cycle
module ram_lvt_mrmw #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned NUM_R  = 4,
  parameter int unsigned NUM_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_W-1:0]          w_enb,
  input  logic [NUM_W*ADDR_W-1:0]   w_addr,
  input  logic [NUM_W*DATA_W-1:0]   w_din,
  input  logic [NUM_R-1:0]          r_enb,
  input  logic [NUM_R*ADDR_W-1:0]   r_addr,
  output logic [NUM_R*DATA_W-1:0]   r_dout,
  output logic [NUM_R-1:0]          r_valid,
  output logic                      w_conflict
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LVT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

  // Bank storage: [write row][read copy][address]; never reset.
  logic [DATA_W-1:0] bank_mem [NUM_W][NUM_R][DEPTH];
  // LVT kept in flops so it can be cleared by reset.
  logic [LVT_W-1:0]  lvt_q    [DEPTH];

  logic [NUM_R*DATA_W-1:0] r_dout_q, r_dout_d;
  logic [NUM_R-1:0]        r_valid_q, r_valid_d;
  logic                    w_conflict_q, w_conflict_d;

  // Bank writes: every read copy of row w stores port w's data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned w = 0; w < NUM_W; w++) begin
        if (w_enb[w]) begin
          for (int unsigned r = 0; r < NUM_R; r++) begin
            bank_mem[w][r][w_addr[w*ADDR_W +: ADDR_W]] <= w_din[w*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // LVT update; ascending loop makes the highest enabled port win a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        lvt_q[a] <= '0;
      end
    end else begin
      for (int unsigned w = 0; w < NUM_W; w++) begin
        if (w_enb[w]) begin
          lvt_q[w_addr[w*ADDR_W +: ADDR_W]] <= LVT_W'(w);
        end
      end
    end
  end

  // Read path: LVT lookup and bank read both see pre-write contents (read-first).
  always_comb begin
    r_dout_d  = r_dout_q;
    r_valid_d = r_enb;
    for (int unsigned r = 0; r < NUM_R; r++) begin
      if (r_enb[r]) begin
        r_dout_d[r*DATA_W +: DATA_W] = bank_mem[0][r][r_addr[r*ADDR_W +: ADDR_W]];
        for (int unsigned w = 1; w < NUM_W; w++) begin
          if (lvt_q[r_addr[r*ADDR_W +: ADDR_W]] == LVT_W'(w)) begin
            r_dout_d[r*DATA_W +: DATA_W] = bank_mem[w][r][r_addr[r*ADDR_W +: ADDR_W]];
          end
        end
      end
    end
  end

  // Same-address detection across every pair of enabled write ports.
  always_comb begin
    w_conflict_d = 1'b0;
    for (int unsigned i = 0; i < NUM_W; i++) begin
      for (int unsigned j = i + 1; j < NUM_W; j++) begin
        if (w_enb[i] && w_enb[j] &&
            (w_addr[i*ADDR_W +: ADDR_W] == w_addr[j*ADDR_W +: ADDR_W])) begin
          w_conflict_d = 1'b1;
        end
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_q     <= '0;
      r_valid_q    <= '0;
      w_conflict_q <= 1'b0;
    end else begin
      r_dout_q     <= r_dout_d;
      r_valid_q    <= r_valid_d;
      w_conflict_q <= w_conflict_d;
    end
  end

  assign r_dout     = r_dout_q;
  assign r_valid    = r_valid_q;
  assign w_conflict = w_conflict_q;

endmodule
